// File: rtl/eth_tx_buf_if.sv
// Byte-stream handshake between an upstream frame source and eth_tx_buf.
// The buffer side uses the slave modport.
interface eth_tx_buf_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_tx_buf.sv
// Single-frame store-and-forward buffer in front of the RMII transmitter: stores,
// pads to minimum length, drops oversize frames and hands the stored frame to eth_tx.
module eth_tx_buf #(
    parameter logic [10:0] FRAME_MAX_SIZE = 11'd1514,
    parameter logic [10:0] FRAME_MIN_SIZE = 11'd60,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    eth_tx_buf_if.slave   s_if,
    output logic          o_tx_en,
    input  logic          i_tx_ready,
    input  logic [10:0]   i_ram_adr,
    input  logic          i_ram_re,
    output logic [7:0]    o_ram_data,
    output logic [10:0]   o_ram_data_size,
    output logic          o_drop,
    output logic          o_busy
);

    typedef enum logic [2:0] {
        RECV    = 3'd0,
        PAD     = 3'd1,
        START   = 3'd2,
        WAIT_TX = 3'd3,
        DROP    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] wr_cnt_q, wr_cnt_d;
    logic [10:0] size_q, size_d;
    logic        drop_q, drop_d;
    logic [7:0]  rd_data_q;

    logic [7:0]  mem [0:2047];
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [10:0] wr_inc;
    logic        s_ready;
    logic        xfer;

    assign s_ready     = (state_q == RECV) || (state_q == DROP);
    assign s_if.s_ready = s_ready;
    assign xfer        = s_if.s_valid && s_ready;
    assign wr_inc      = wr_cnt_q + 11'd1;

    assign o_tx_en         = (state_q == START);
    assign o_busy          = (state_q != RECV);
    assign o_drop          = drop_q;
    assign o_ram_data      = rd_data_q;
    assign o_ram_data_size = size_q;

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        size_d    = size_q;
        drop_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = s_if.s_data;
        case (state_q)
            RECV: begin
                if (xfer) begin
                    // A full buffer means this byte overflows the frame; it is never stored.
                    if (wr_cnt_q == FRAME_MAX_SIZE) begin
                        if (s_if.s_last) begin
                            drop_d   = 1'b1;
                            wr_cnt_d = 11'd0;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_inc;
                        if (s_if.s_last) begin
                            if (wr_inc >= FRAME_MIN_SIZE) begin
                                size_d  = wr_inc;
                                state_d = START;
                            end else begin
                                state_d = PAD;
                            end
                        end
                    end
                end
            end
            PAD: begin
                mem_we    = 1'b1;
                mem_wdata = PAD_BYTE;
                wr_cnt_d  = wr_inc;
                if (wr_cnt_q == FRAME_MIN_SIZE - 11'd1) begin
                    size_d  = FRAME_MIN_SIZE;
                    state_d = START;
                end
            end
            START: begin
                if (!i_tx_ready) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_ready) begin
                    wr_cnt_d = 11'd0;
                    state_d  = RECV;
                end
            end
            DROP: begin
                if (xfer && s_if.s_last) begin
                    drop_d   = 1'b1;
                    wr_cnt_d = 11'd0;
                    state_d  = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= RECV;
            wr_cnt_q <= 11'd0;
            size_q   <= 11'd0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            size_q   <= size_d;
            drop_q   <= drop_d;
        end
    end

    // Frame RAM is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_cnt_q] <= mem_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q <= 8'h00;
        end else if (i_ram_re) begin
            rd_data_q <= mem[i_ram_adr];
        end
    end

endmodule

// File: tb/tb_eth_tx_buf.sv
// Directed bench for eth_tx_buf: frame storage, padding, oversize drop, eth_tx handshake
// and reset during transmission.
module tb_eth_tx_buf;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_tx_en;
    logic        i_tx_ready;
    logic [10:0] i_ram_adr;
    logic        i_ram_re;
    logic [7:0]  o_ram_data;
    logic [10:0] o_ram_data_size;
    logic        o_drop;
    logic        o_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int drop_cnt = 0;
    int rise_cnt = 0;
    logic tx_en_prev = 1'b0;

    always #5 i_clk = ~i_clk;

    eth_tx_buf_if s_if ();

    eth_tx_buf dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .s_if            (s_if),
        .o_tx_en         (o_tx_en),
        .i_tx_ready      (i_tx_ready),
        .i_ram_adr       (i_ram_adr),
        .i_ram_re        (i_ram_re),
        .o_ram_data      (o_ram_data),
        .o_ram_data_size (o_ram_data_size),
        .o_drop          (o_drop),
        .o_busy          (o_busy)
    );

    always @(negedge i_clk) begin
        if (o_drop === 1'b1) drop_cnt++;
        if (o_tx_en === 1'b1 && tx_en_prev !== 1'b1) rise_cnt++;
        tx_en_prev = o_tx_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input int first, input int n_total, input logic [7:0] base, input bit with_last);
        for (int i = first; i < n_total; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = 8'(int'(base) + i);
            s_if.s_last  = with_last && (i == n_total - 1);
            step();
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic rd(input int adr, input logic [7:0] exp);
        i_ram_adr = 11'(adr);
        i_ram_re  = 1'b1;
        step();
        i_ram_re  = 1'b0;
        chk($sformatf("rd[%0d]", adr), 32'(o_ram_data), 32'(exp));
    endtask

    // eth_tx model: samples tx_en, drops ready one edge later, holds it low, then releases.
    task automatic handshake(input string tag);
        step();
        chk({tag, "_txen_s"}, 32'(o_tx_en), 32'd1);
        step();
        i_tx_ready = 1'b0;
        chk({tag, "_txen_s1"}, 32'(o_tx_en), 32'd1);
        step();
        chk({tag, "_txen_s2"}, 32'(o_tx_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_rdy_hold"}, 32'(s_if.s_ready), 32'd0);
            step();
        end
        chk({tag, "_busy_hold"}, 32'(o_busy), 32'd1);
        i_tx_ready = 1'b1;
        step();
        chk({tag, "_rdy_back"}, 32'(s_if.s_ready), 32'd1);
        chk({tag, "_busy_off"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_tx_ready   = 1'b1;
        i_ram_adr    = 11'd0;
        i_ram_re     = 1'b0;
        s_if.s_data  = 8'h00;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;

        #12;
        chk("rst_ready", 32'(s_if.s_ready), 32'd1);
        chk("rst_txen", 32'(o_tx_en), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_rdata", 32'(o_ram_data), 32'd0);
        chk("rst_size", 32'(o_ram_data_size), 32'd0);
        step();
        i_rst_n = 1'b1;

        // 64-byte frame, data = index
        send(0, 64, 8'h00, 1'b1);
        chk("f64_txen", 32'(o_tx_en), 32'd1);
        chk("f64_ready", 32'(s_if.s_ready), 32'd0);
        chk("f64_size", 32'(o_ram_data_size), 32'd64);
        for (int a = 0; a < 64; a++) rd(a, 8'(a));
        i_ram_adr = 11'd5;
        step();
        chk("rd_hold", 32'(o_ram_data), 32'h3F);
        handshake("f64");

        // 10-byte frame needs 50 pad cycles
        send(0, 10, 8'hA0, 1'b1);
        chk("f10_txen0", 32'(o_tx_en), 32'd0);
        chk("f10_ready", 32'(s_if.s_ready), 32'd0);
        chk("f10_busy", 32'(o_busy), 32'd1);
        for (int k = 0; k < 49; k++) step();
        chk("f10_txen49", 32'(o_tx_en), 32'd0);
        step();
        chk("f10_txen50", 32'(o_tx_en), 32'd1);
        chk("f10_size", 32'(o_ram_data_size), 32'd60);
        for (int a = 0; a < 10; a++) rd(a, 8'(8'hA0 + a));
        for (int a = 10; a < 60; a++) rd(a, 8'h00);
        handshake("f10");

        // maximum-size frame
        send(0, 1514, 8'h00, 1'b1);
        chk("f1514_txen", 32'(o_tx_en), 32'd1);
        chk("f1514_size", 32'(o_ram_data_size), 32'd1514);
        chk("f1514_nodrop", 32'(drop_cnt), 32'd0);
        rd(0, 8'h00);
        rd(1513, 8'hE9);
        handshake("f1514");

        // 1515 bytes: overflow byte carries last
        send(0, 1515, 8'h00, 1'b1);
        chk("f1515_drop", 32'(o_drop), 32'd1);
        chk("f1515_txen", 32'(o_tx_en), 32'd0);
        chk("f1515_busy", 32'(o_busy), 32'd0);
        chk("f1515_ready", 32'(s_if.s_ready), 32'd1);
        step();
        chk("f1515_drop_w", 32'(o_drop), 32'd0);
        chk("f1515_txen2", 32'(o_tx_en), 32'd0);
        send(0, 64, 8'h40, 1'b1);
        chk("f64b_txen", 32'(o_tx_en), 32'd1);
        chk("f64b_size", 32'(o_ram_data_size), 32'd64);
        rd(0, 8'h40);
        rd(63, 8'h7F);
        handshake("f64b");

        // 1516 bytes: overflow passes through DROP
        send(0, 1515, 8'h00, 1'b0);
        chk("f1516_busy", 32'(o_busy), 32'd1);
        chk("f1516_ready", 32'(s_if.s_ready), 32'd1);
        chk("f1516_nodrop", 32'(o_drop), 32'd0);
        send(1515, 1516, 8'h00, 1'b1);
        chk("f1516_drop", 32'(o_drop), 32'd1);
        chk("f1516_busy2", 32'(o_busy), 32'd0);
        chk("f1516_txen", 32'(o_tx_en), 32'd0);
        step();
        chk("f1516_drop_w", 32'(o_drop), 32'd0);

        // back-to-back 60-byte frames with valid held high
        send(0, 60, 8'h10, 1'b1);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h55;
        chk("bb1_txen", 32'(o_tx_en), 32'd1);
        chk("bb1_size", 32'(o_ram_data_size), 32'd60);
        rd(0, 8'h10);
        rd(59, 8'h4B);
        handshake("bb1");
        send(0, 60, 8'h55, 1'b1);
        chk("bb2_txen", 32'(o_tx_en), 32'd1);
        chk("bb2_size", 32'(o_ram_data_size), 32'd60);
        rd(0, 8'h55);
        rd(1, 8'h56);
        rd(59, 8'h90);
        handshake("bb2");

        // reset while in WAIT_TX
        send(0, 64, 8'hC0, 1'b1);
        chk("rw_txen", 32'(o_tx_en), 32'd1);
        step();
        step();
        i_tx_ready = 1'b0;
        step();
        chk("rw_wait_txen", 32'(o_tx_en), 32'd0);
        chk("rw_wait_busy", 32'(o_busy), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rw_rst_txen", 32'(o_tx_en), 32'd0);
        chk("rw_rst_ready", 32'(s_if.s_ready), 32'd1);
        chk("rw_rst_busy", 32'(o_busy), 32'd0);
        chk("rw_rst_size", 32'(o_ram_data_size), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        i_tx_ready = 1'b1;
        send(0, 60, 8'h20, 1'b1);
        chk("rw_f_txen", 32'(o_tx_en), 32'd1);
        chk("rw_f_size", 32'(o_ram_data_size), 32'd60);
        rd(0, 8'h20);
        rd(59, 8'h5B);
        rd(60, 8'hFC);
        handshake("rw_f");

        step();
        chk("drop_total", 32'(drop_cnt), 32'd2);
        chk("txen_rises", 32'(rise_cnt), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
